// File: rtl/sd_pkg.sv
// Shared SD-card definitions: data-phase states, tokens, error codes and the
// CRC16-CCITT byte update used by the block receiver.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TOKEN,
        DATA,
        CRC1,
        CRC2,
        CHECK,
        FAIL
    } sd_state_e;

    localparam logic [7:0] SD_TOKEN_START = 8'hFE;

    // Codes 1-4 belong to the command controller.
    localparam logic [7:0] ERR_TOKEN_TO = 8'd5;
    localparam logic [7:0] ERR_DATA_TOK = 8'd6;
    localparam logic [7:0] ERR_CRC      = 8'd7;

    // CRC16-CCITT (poly 1021h), MSB first, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_block_rx_if.sv
// Pin and port bundle of the SD block receiver: controller handshake, SPI pins
// and the sector-RAM write port. slave = receiver side, master = surroundings.
interface sd_block_rx_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              spi_cs;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        errorno;

    modport slave (
        input  start, spi_miso,
        output spi_cs, spi_sclk, spi_mosi, buf_we, buf_addr, buf_data,
               busy, done, error, errorno
    );

    modport master (
        output start, spi_miso,
        input  spi_cs, spi_sclk, spi_mosi, buf_we, buf_addr, buf_data,
               busy, done, error, errorno
    );
endinterface

// File: rtl/sd_spi_rx_byte.sv
// SPI mode-0 byte receiver: SCLK divider plus MSB-first shifter. Bytes run
// back-to-back while en_i is high; dropping en_i parks SCLK low.
module sd_spi_rx_byte #(
    parameter int CLK_DIV = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       sclk_q, sclk_d;
    logic [3:0] bits_q, bits_d;
    logic [7:0] shift_q, shift_d;
    logic       valid_q, valid_d;

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        div_d   = div_q;
        sclk_d  = sclk_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
            bits_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
                shift_d = {shift_q[6:0], miso_i};
                bits_d  = bits_q + 4'd1;
            end else if (bits_q == 4'd8) begin
                // Falling edge after the 8th rise closes the byte.
                bits_d  = '0;
                valid_d = 1'b1;
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            bits_q  <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign sclk_o       = sclk_q;
    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
endmodule

// File: rtl/sd_block_rx.sv
// SD single-block read data phase: hunts the FEh token, streams BLOCK_LEN bytes
// into the sector RAM, then checks the trailing CRC16 and reports done/error.
module sd_block_rx
    import sd_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int BLOCK_LEN     = 512,
    parameter int TOKEN_TIMEOUT = 4095
) (
    input  logic          clock,
    input  logic          reset_n,
    sd_block_rx_if.slave  bus
);
    localparam int ADDR_W = $clog2(BLOCK_LEN);
    localparam int TCNT_W = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLOCK_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TOKEN_TIMEOUT);

    sd_state_e         state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       rx_crc_q, rx_crc_d;
    logic [ADDR_W-1:0] addr_q, addr_d, baddr_q, baddr_d;
    logic [7:0]        bdata_q, bdata_d, errorno_q, errorno_d;
    logic              cs_q, cs_d, busy_q, busy_d, done_q, done_d;
    logic              error_q, error_d, we_q, we_d;
    logic              fail_req;
    logic [7:0]        fail_code;
    logic              rx_en, rx_valid;
    logic [7:0]        rx_byte;

    assign rx_en = state_q inside {TOKEN, DATA, CRC1, CRC2};

    sd_spi_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clock        (clock),
        .reset_n      (reset_n),
        .en_i         (rx_en),
        .miso_i       (bus.spi_miso),
        .sclk_o       (bus.spi_sclk),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte)
    );

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        crc_d     = crc_q;
        rx_crc_d  = rx_crc_q;
        addr_d    = addr_q;
        baddr_d   = baddr_q;
        bdata_d   = bdata_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        error_d   = error_q;
        errorno_d = errorno_q;
        done_d    = 1'b0;
        we_d      = 1'b0;
        fail_req  = 1'b0;
        fail_code = 8'h00;
        case (state_q)
            IDLE: begin
                // The done cycle still belongs to the finished block, so start is refused there.
                if (bus.start && !done_q) begin
                    error_d   = 1'b0;
                    errorno_d = 8'h00;
                    tcnt_d    = '0;
                    crc_d     = '0;
                    addr_d    = '0;
                    baddr_d   = '0;
                    busy_d    = 1'b1;
                    cs_d      = 1'b0;
                    state_d   = TOKEN;
                end
            end
            TOKEN: if (rx_valid) begin
                if (rx_byte == SD_TOKEN_START) begin
                    state_d = DATA;
                end else if (rx_byte[7:4] == 4'h0) begin
                    fail_req  = 1'b1;
                    fail_code = ERR_DATA_TOK;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TCNT_LAST) begin
                        fail_req  = 1'b1;
                        fail_code = ERR_TOKEN_TO;
                    end
                end
            end
            DATA: if (rx_valid) begin
                we_d    = 1'b1;
                baddr_d = addr_q;
                bdata_d = rx_byte;
                crc_d   = crc16_byte(crc_q, rx_byte);
                if (addr_q == ADDR_LAST) state_d = CRC1;
                else                     addr_d  = addr_q + 1'b1;
            end
            CRC1: if (rx_valid) begin
                rx_crc_d[15:8] = rx_byte;
                state_d        = CRC2;
            end
            CRC2: if (rx_valid) begin
                rx_crc_d[7:0] = rx_byte;
                state_d       = CHECK;
            end
            CHECK: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (rx_crc_q == crc_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    fail_req  = 1'b1;
                    fail_code = ERR_CRC;
                end
            end
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fail_req) begin
            state_d   = FAIL;
            error_d   = 1'b1;
            errorno_d = fail_code;
            cs_d      = 1'b1;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            addr_q    <= '0;
            baddr_q   <= '0;
            bdata_q   <= '0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            errorno_q <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            crc_q     <= crc_d;
            rx_crc_q  <= rx_crc_d;
            addr_q    <= addr_d;
            baddr_q   <= baddr_d;
            bdata_q   <= bdata_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            errorno_q <= errorno_d;
            we_q      <= we_d;
        end
    end

    assign bus.spi_cs   = cs_q;
    assign bus.spi_mosi = 1'b1;
    assign bus.buf_we   = we_q;
    assign bus.buf_addr = baddr_q;
    assign bus.buf_data = bdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.errorno  = errorno_q;
endmodule

// File: tb/tb_sd_block_rx.sv
// Bench for sd_block_rx: a card model feeds scripted byte streams over SPI and
// a monitor scores every RAM write, byte spacing and the done latency.
module tb_sd_block_rx;
    localparam int CLK_DIV   = 2;
    localparam int BLOCK_LEN = 512;
    localparam int TT        = 31;
    localparam int ADDR_W    = $clog2(BLOCK_LEN);
    localparam int BUDGET    = 25000;

    typedef struct {
        string       name;
        int          n_ff;
        logic [7:0]  token;
        bit          inc;
        bit          crc_fixed;
        logic [15:0] crc_val;
        logic [15:0] crc_xor;
        bit          exp_done;
        bit          exp_err;
        logic [7:0]  exp_errno;
        int          exp_we;
        int          exp_bytes;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    sd_block_rx_if #(.ADDR_W(ADDR_W)) bus ();

    sd_block_rx #(
        .CLK_DIV       (CLK_DIV),
        .BLOCK_LEN     (BLOCK_LEN),
        .TOKEN_TIMEOUT (TT)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int we_cnt, data_bad, gap_bad, done_cnt, done_lat, fall_cnt, last_fall_cyc, last_we_cyc;
    logic [7:0] exp_blk [BLOCK_LEN];
    logic [7:0] card_q [$];
    logic [7:0] cur;
    int  bit_idx;
    bit  active = 1'b0;
    logic prev_sclk = 1'b0;
    vec_t vecs [5];

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] pop_byte();
        if (card_q.size() == 0) return 8'hFF;
        return card_q.pop_front();
    endfunction

    // Card model (changes MISO after SCLK falls) and write monitor.
    always @(negedge clk) begin
        if (bus.spi_cs !== 1'b0) begin
            active       = 1'b0;
            bus.spi_miso = 1'b1;
        end else begin
            if (!active) begin
                active  = 1'b1;
                bit_idx = 7;
                cur     = pop_byte();
            end else if (prev_sclk && !bus.spi_sclk) begin
                fall_cnt++;
                last_fall_cyc = cyc;
                if (bit_idx == 0) begin
                    cur     = pop_byte();
                    bit_idx = 7;
                end else begin
                    bit_idx--;
                end
            end
            bus.spi_miso = cur[bit_idx];
        end
        prev_sclk = bus.spi_sclk;
        if (bus.buf_we === 1'b1) begin
            if (we_cnt >= BLOCK_LEN || bus.buf_addr != ADDR_W'(we_cnt) || bus.buf_data != exp_blk[we_cnt])
                data_bad++;
            if (we_cnt > 0 && cyc - last_we_cyc != 16 * CLK_DIV) gap_bad++;
            last_we_cyc = cyc;
            we_cnt++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_lat = cyc - last_fall_cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model();
        logic [15:0] r;
        logic        fb;
        r = 16'h0000;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[15] ^ exp_blk[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    task automatic prepare(input vec_t v);
        logic [15:0] crc;
        card_q.delete();
        for (int i = 0; i < BLOCK_LEN; i++) exp_blk[i] = v.inc ? 8'(i) : 8'hFF;
        crc = v.crc_fixed ? v.crc_val : (crc_model() ^ v.crc_xor);
        for (int i = 0; i < v.n_ff; i++) card_q.push_back(8'hFF);
        card_q.push_back(v.token);
        for (int i = 0; i < BLOCK_LEN; i++) card_q.push_back(exp_blk[i]);
        card_q.push_back(crc[15:8]);
        card_q.push_back(crc[7:0]);
        we_cnt = 0; data_bad = 0; gap_bad = 0; done_cnt = 0;
        done_lat = -1; fall_cnt = 0; last_fall_cyc = 0; last_we_cyc = 0;
    endtask

    task automatic kick(input string name);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check({name, ".busy_after_start"}, bus.busy, 1);
        check({name, ".cs_after_start"}, bus.spi_cs, 0);
        check({name, ".error_cleared"}, bus.error, 0);
        check({name, ".errorno_cleared"}, bus.errorno, 0);
        check({name, ".mosi"}, bus.spi_mosi, 1);
    endtask

    task automatic finish(input vec_t v, input bit start_on_done);
        int n = 0;
        while (!(bus.done === 1'b1 || bus.error === 1'b1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({v.name, ".finished_in_budget"}, n < BUDGET, 1);
        if (start_on_done) begin
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
            check({v.name, ".start_on_done_ignored_busy"}, bus.busy, 0);
            check({v.name, ".start_on_done_ignored_cs"}, bus.spi_cs, 1);
        end
        repeat (3) @(negedge clk);
        check({v.name, ".done_pulses"}, done_cnt, v.exp_done);
        check({v.name, ".error"}, bus.error, v.exp_err);
        check({v.name, ".errorno"}, bus.errorno, v.exp_errno);
        check({v.name, ".cs_released"}, bus.spi_cs, 1);
        check({v.name, ".busy_low"}, bus.busy, 0);
        check({v.name, ".we_count"}, we_cnt, v.exp_we);
        check({v.name, ".write_addr_data_bad"}, data_bad, 0);
        check({v.name, ".byte_gap_bad"}, gap_bad, 0);
        check({v.name, ".sclk_falls"}, fall_cnt, 8 * v.exp_bytes);
        if (v.exp_done) begin
            check({v.name, ".done_latency"}, done_lat, 2);
            check({v.name, ".addr_no_wrap"}, bus.buf_addr, BLOCK_LEN - 1);
        end
    endtask

    task automatic wait_we(input int target);
        int n = 0;
        while (we_cnt < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("wait_for_writes_in_budget", n < BUDGET, 1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".cs"}, bus.spi_cs, 1);
        check({name, ".sclk"}, bus.spi_sclk, 0);
        check({name, ".mosi"}, bus.spi_mosi, 1);
        check({name, ".buf_we"}, bus.buf_we, 0);
        check({name, ".buf_addr"}, bus.buf_addr, 0);
        check({name, ".buf_data"}, bus.buf_data, 0);
        check({name, ".busy"}, bus.busy, 0);
        check({name, ".done"}, bus.done, 0);
        check({name, ".error"}, bus.error, 0);
        check({name, ".errorno"}, bus.errorno, 0);
    endtask

    initial begin
        vecs[0] = '{"err_token", 1, 8'h08, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 8'd6, 0, 2};
        vecs[1] = '{"ff_block", 3, 8'hFE, 1'b0, 1'b1, 16'h7FA1, 16'h0, 1'b1, 1'b0, 8'd0, BLOCK_LEN, 3 + 1 + BLOCK_LEN + 2};
        vecs[2] = '{"inc_block", 0, 8'hFE, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 8'd0, BLOCK_LEN, 1 + BLOCK_LEN + 2};
        vecs[3] = '{"crc_bad", 2, 8'hFE, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b0, 1'b1, 8'd7, BLOCK_LEN, 2 + 1 + BLOCK_LEN + 2};
        vecs[4] = '{"token_timeout", 600, 8'hFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 8'd5, 0, TT + 1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            prepare(vecs[i]);
            kick(vecs[i].name);
            finish(vecs[i], 1'b0);
        end

        // Start mid-block must be ignored; reset mid-block must abort at once.
        prepare(vecs[2]);
        kick("mid_block");
        wait_we(50);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_we(100);
        check("mid_block.ignored_start_writes_ok", data_bad, 0);
        check("mid_block.busy_kept", bus.busy, 1);
        #7 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        repeat (4) @(negedge clk);
        check("mid_reset.no_more_writes", we_cnt, 100);
        rst_n = 1'b1;
        @(negedge clk);

        prepare(vecs[2]);
        kick("after_reset");
        finish(vecs[2], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not reach its summary, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
